// File: rtl/pc_flow_ctrl.sv
// Control-flow sequencer around the PC update unit: stalls fetch while a
// branch/call/return is unresolved, then issues a one-cycle PC redirect.
module pc_flow_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_branch,
   input  logic              id_call,
   input  logic              id_ret,
   input  logic              ex_resolve,
   input  logic              ex_pc_src,
   input  logic [ADDR_W-1:0] ex_pc_target,
   input  logic              wb_ret_valid,
   input  logic [ADDR_W-1:0] wb_ret_addr,
   output logic              stall_if,
   output logic              flush_id_ex,
   output logic              flush_if_id,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_next,
   output logic              busy,
   output logic              err_timeout,
   output logic [2:0]        state_dbg
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_EX  = 3'd1,
      WAIT_WB  = 3'd2,
      REDIRECT = 3'd3,
      ERR      = 3'd4
   } state_t;

   state_t            state;
   logic [CW-1:0]     wait_cnt;
   logic [ADDR_W-1:0] pc_next_q;
   logic              expired;

   // ex_resolve and wb_ret_valid are single-cycle qualifiers with no
   // backpressure: an event is consumed in the cycle it is seen, or lost.
   assign expired = (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         pc_next_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (id_branch || id_call) begin
                  state <= WAIT_EX;
               end else if (id_ret) begin
                  state <= WAIT_WB;
               end
            end
            WAIT_EX: begin
               // A resolve in the expiry cycle still wins over the watchdog.
               if (ex_resolve) begin
                  if (ex_pc_src) begin
                     state     <= REDIRECT;
                     pc_next_q <= ex_pc_target;
                  end else begin
                     state <= IDLE;
                  end
               end else if (expired) begin
                  state <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WAIT_WB: begin
               if (wb_ret_valid) begin
                  state     <= REDIRECT;
                  pc_next_q <= wb_ret_addr;
               end else if (expired) begin
                  state <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            REDIRECT: state <= IDLE;
            ERR:      state <= ERR;
            default:  state <= IDLE;
         endcase
      end
   end

   // The decode cycle itself stalls fetch but lets the control op move to EX.
   assign stall_if    = !rst && ((state != IDLE) || id_branch || id_call || id_ret);
   assign flush_id_ex = (state == WAIT_EX) || (state == WAIT_WB) ||
                        (state == REDIRECT) || (state == ERR);
   assign pc_load     = (state == REDIRECT);
   assign flush_if_id = (state == REDIRECT);
   assign pc_next     = pc_next_q;
   assign busy        = (state != IDLE);
   assign err_timeout = (state == ERR);
   assign state_dbg   = state;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed vector table, corner-case sequences and
// random traffic checked against a transaction-level reference model.
module tb_pc_flow_ctrl;

   localparam int TIMEOUT = 15;
   localparam int AW      = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_branch, id_call, id_ret;
   logic          ex_resolve, ex_pc_src;
   logic [AW-1:0] ex_pc_target;
   logic          wb_ret_valid;
   logic [AW-1:0] wb_ret_addr;
   logic          stall_if, flush_id_ex, flush_if_id, pc_load, busy, err_timeout;
   logic [AW-1:0] pc_next;
   logic [2:0]    state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   pc_flow_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .id_branch(id_branch), .id_call(id_call), .id_ret(id_ret),
      .ex_resolve(ex_resolve), .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
      .wb_ret_valid(wb_ret_valid), .wb_ret_addr(wb_ret_addr),
      .stall_if(stall_if), .flush_id_ex(flush_id_ex), .flush_if_id(flush_if_id),
      .pc_load(pc_load), .pc_next(pc_next), .busy(busy),
      .err_timeout(err_timeout), .state_dbg(state_dbg)
   );

   // ---------------- clock / time bound ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL time_bound: simulation exceeded limit (act=running req=finished)");
      $fatal(1, "time bound expired");
   end

   // ---------------- reference model ----------------
   // Phase: 0 idle, 1 waiting on EX, 2 waiting on WB, 3 redirecting, 4 dead.
   int            m_phase  = 0;
   int            m_waited = 0;
   logic [AW-1:0] m_pc     = '0;

   function automatic logic [22:0] model_out();
      logic s, f, l, b, e;
      s = !rst && (m_phase != 0 || id_branch || id_call || id_ret);
      f = (m_phase != 0);
      l = (m_phase == 3);
      b = (m_phase != 0);
      e = (m_phase == 4);
      return {s, f, l, l, b, e, m_pc};
   endfunction

   function automatic logic [22:0] dut_out();
      return {stall_if, flush_id_ex, flush_if_id, pc_load, busy, err_timeout, pc_next};
   endfunction

   task automatic model_advance();
      if (rst) begin
         m_phase = 0; m_waited = 0; m_pc = '0;
      end else if (m_phase == 0) begin
         m_waited = 0;
         if (id_branch || id_call) m_phase = 1;
         else if (id_ret)          m_phase = 2;
      end else if (m_phase == 1 || m_phase == 2) begin
         if (m_phase == 1 && ex_resolve) begin
            if (ex_pc_src) begin m_pc = ex_pc_target; m_phase = 3; end
            else m_phase = 0;
         end else if (m_phase == 2 && wb_ret_valid) begin
            m_pc = wb_ret_addr; m_phase = 3;
         end else if (m_waited + 1 >= TIMEOUT) begin
            m_phase = 4;
         end else begin
            m_waited++;
         end
      end else if (m_phase == 3) begin
         m_phase = 0;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic r, b, c, rt, res, src, input logic [AW-1:0] tgt,
                         input logic wv, input logic [AW-1:0] wa);
      rst = r; id_branch = b; id_call = c; id_ret = rt;
      ex_resolve = res; ex_pc_src = src; ex_pc_target = tgt;
      wb_ret_valid = wv; wb_ret_addr = wa;
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, '0, 0, '0);
   endtask

   // Called at negedge+1 with inputs applied: compare to model, then clock.
   task automatic finish_cycle(input string name);
      check(name, {9'd0, dut_out()}, {9'd0, model_out()});
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic step(input string name, input logic r, b, c, rt, res, src,
                       input logic [AW-1:0] tgt, input logic wv, input logic [AW-1:0] wa);
      set_in(r, b, c, rt, res, src, tgt, wv, wa);
      #1;
      finish_cycle(name);
   endtask

   task automatic nop(input string name);
      step(name, 0, 0, 0, 0, 0, 0, '0, 0, '0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic b, c, r, res, src;
      logic [AW-1:0] tgt;
      logic wv;
      logic [AW-1:0] wa;
      logic e_stall, e_fidex, e_load, e_busy, e_err;
      logic [AW-1:0] e_pc;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(input logic b, c, r, res, src, input logic [AW-1:0] tgt,
                               input logic wv, input logic [AW-1:0] wa,
                               input logic s, f, l, bz, e, input logic [AW-1:0] pc);
      vec_t v;
      v.b = b; v.c = c; v.r = r; v.res = res; v.src = src; v.tgt = tgt;
      v.wv = wv; v.wa = wa;
      v.e_stall = s; v.e_fidex = f; v.e_load = l; v.e_busy = bz; v.e_err = e; v.e_pc = pc;
      return v;
   endfunction

   initial begin
      // taken branch
      tbl[0]  = mk(1,0,0,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'h0000);
      tbl[1]  = mk(0,0,0,1,1,16'h0123,0,16'h0000, 1,1,0,1,0,16'h0000);
      tbl[2]  = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,1,1,0,16'h0123);
      tbl[3]  = mk(0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,16'h0123);
      // not-taken branch resolved at T+3
      tbl[4]  = mk(1,0,0,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'h0123);
      tbl[5]  = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[6]  = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[7]  = mk(0,0,0,1,0,16'h5555,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[8]  = mk(0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,16'h0123);
      // return with an ignored ex_resolve
      tbl[9]  = mk(0,0,1,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'h0123);
      tbl[10] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[11] = mk(0,0,0,1,1,16'h7777,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[12] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'h0123);
      tbl[13] = mk(0,0,0,0,0,16'h0000,1,16'hBEEF, 1,1,0,1,0,16'h0123);
      tbl[14] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,1,1,0,16'hBEEF);
      tbl[15] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,16'hBEEF);
      // priority branch > ret; id_call and wb_ret_valid ignored in WAIT_EX
      tbl[16] = mk(1,0,1,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'hBEEF);
      tbl[17] = mk(0,1,0,0,0,16'h0000,1,16'h1111, 1,1,0,1,0,16'hBEEF);
      tbl[18] = mk(0,0,0,1,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'hBEEF);
      tbl[19] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,16'hBEEF);
      // back-to-back: not-taken then immediate new branch, taken
      tbl[20] = mk(1,0,0,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'hBEEF);
      tbl[21] = mk(0,0,0,1,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'hBEEF);
      tbl[22] = mk(1,0,0,0,0,16'h0000,0,16'h0000, 1,0,0,0,0,16'hBEEF);
      tbl[23] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,0,1,0,16'hBEEF);
      tbl[24] = mk(0,0,0,1,1,16'h0042,0,16'h0000, 1,1,0,1,0,16'hBEEF);
      tbl[25] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 1,1,1,1,0,16'h0042);
      tbl[26] = mk(0,0,0,0,0,16'h0000,0,16'h0000, 0,0,0,0,0,16'h0042);
   end

   // ---------------- test sequence ----------------
   initial begin
      set_in(1, 0, 0, 0, 0, 0, '0, 0, '0);
      @(posedge clk);
      @(posedge clk);
      model_advance();
      @(negedge clk);

      // reset state, with id_branch asserted to show stall_if forced low
      step("reset", 1, 1, 0, 0, 0, 0, '0, 0, '0);
      idle_in(); #1;
      check("reset_outputs", {9'd0, dut_out()}, 32'd0);
      finish_cycle("reset_idle");

      for (int i = 0; i < 27; i++) begin
         set_in(0, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].res, tbl[i].src,
                tbl[i].tgt, tbl[i].wv, tbl[i].wa);
         #1;
         check($sformatf("vec%0d", i),
               {9'd0, stall_if, flush_id_ex, flush_if_id, pc_load, busy, err_timeout, pc_next},
               {9'd0, tbl[i].e_stall, tbl[i].e_fidex, tbl[i].e_load, tbl[i].e_load,
                tbl[i].e_busy, tbl[i].e_err, tbl[i].e_pc});
         finish_cycle($sformatf("vec%0d_model", i));
      end

      // watchdog expiry and recovery through reset
      step("wd_call", 0, 0, 1, 0, 0, 0, '0, 0, '0);
      for (int i = 0; i < TIMEOUT; i++) nop("wd_wait");
      idle_in(); #1;
      check("wd_err", err_timeout, 1);
      check("wd_stall", stall_if, 1);
      step("wd_absorb", 0, 1, 0, 0, 1, 1, 16'h3333, 1, 16'h4444);
      idle_in(); #1;
      check("wd_sticky", err_timeout, 1);
      set_in(1, 0, 0, 0, 0, 0, '0, 0, '0); #1;
      check("wd_rst_stall", stall_if, 0);
      finish_cycle("wd_rst");
      idle_in(); #1;
      check("wd_rst_outputs", {9'd0, dut_out()}, 32'd0);

      // resolve coincident with the last wait cycle wins
      step("co_call", 0, 0, 1, 0, 0, 0, '0, 0, '0);
      for (int i = 0; i < TIMEOUT - 1; i++) nop("co_wait");
      step("co_resolve", 0, 0, 0, 0, 1, 1, 16'h0ABC, 0, '0);
      idle_in(); #1;
      check("co_load", {err_timeout, pc_load, pc_next}, {1'b0, 1'b1, 16'h0ABC});
      nop("co_redirect");

      // watchdog restarts after a back-to-back accept
      step("rs_br1", 0, 1, 0, 0, 0, 0, '0, 0, '0);
      for (int i = 0; i < 9; i++) nop("rs_wait1");
      step("rs_nt", 0, 0, 0, 0, 1, 0, '0, 0, '0);
      step("rs_br2", 0, 1, 0, 0, 0, 0, '0, 0, '0);
      for (int i = 0; i < TIMEOUT - 1; i++) nop("rs_wait2");
      idle_in(); #1;
      check("rs_no_err", {err_timeout, busy}, {1'b0, 1'b1});
      nop("rs_last");
      idle_in(); #1;
      check("rs_err", err_timeout, 1);
      step("rs_rst", 1, 0, 0, 0, 0, 0, '0, 0, '0);

      // reset while in REDIRECT drops the pending load
      step("rr_ret", 0, 0, 0, 1, 0, 0, '0, 0, '0);
      step("rr_wv", 0, 0, 0, 0, 0, 0, '0, 1, 16'h4321);
      idle_in(); #1;
      check("rr_redirect", pc_load, 1);
      set_in(1, 0, 0, 0, 0, 0, '0, 0, '0); #1;
      check("rr_rst_stall", stall_if, 0);
      finish_cycle("rr_rst");
      idle_in(); #1;
      check("rr_dropped", {pc_load, busy, pc_next}, 18'd0);
      finish_cycle("rr_idle");

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step("rand",
              ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              1'($urandom), 16'($urandom),
              ($urandom_range(0, 7) == 0), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Control-flow sequencer that wraps the PC update unit in the 5-stage pipeline. When a branch, call or return is decoded in ID, it stalls fetch and feeds bubbles into ID/EX. It waits for the branch/call resolution from EX, or for the return address from MEM/WB, then issues a one-cycle PC load plus IF/ID flush on a taken redirect. It also enforces a watchdog on the wait.

## Interface
- TIMEOUT, 15: maximum number of consecutive wait cycles before the error trap (≥2).
- ADDR_W, 16: PC width.

Ports:
- clk  in  1  single system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- id_branch  in  1  conditional/unconditional branch decoded in ID this cycle.
- id_call  in  1  call decoded in ID this cycle.
- id_ret  in  1  return decoded in ID this cycle.
- ex_resolve  in  1  PC update unit finished its evaluation this cycle (pulse).
- ex_pc_src  in  1  resolved op is taken (qualified by ex_resolve).
- ex_pc_target  in  ADDR_W  resolved target (qualified by ex_resolve).
- wb_ret_valid  in  1  return address popped and valid this cycle (pulse).
- wb_ret_addr  in  ADDR_W  popped return address.
- stall_if  out  1  hold PC register and IF/ID.
- flush_id_ex  out  1  insert bubble into ID/EX.
- flush_if_id  out  1  clear IF/ID (wrong-path instruction).
- pc_load  out  1  load pc_next into PC this cycle.
- pc_next  out  ADDR_W  redirect address.
- busy  out  1  state ≠ IDLE.
- err_timeout  out  1  sticky watchdog error.

## Operation
- States: IDLE, WAIT_EX, WAIT_WB, REDIRECT, ERR.
- Decode priority when several id_* bits are set: branch > call > ret.
- id_* are examined only in IDLE. They are ignored in all other states.
- IDLE:
  - id_branch or id_call → WAIT_EX.
  - id_ret → WAIT_WB.
  - ex_resolve and wb_ret_valid are ignored.
- WAIT_EX:
  - ex_resolve with ex_pc_src=1 → REDIRECT; pc_next registered from ex_pc_target.
  - ex_resolve with ex_pc_src=0 → IDLE.
  - wb_ret_valid is ignored.
- WAIT_WB:
  - wb_ret_valid → REDIRECT; pc_next registered from wb_ret_addr.
  - ex_resolve is ignored.
- REDIRECT: always → IDLE after one cycle.
- ERR: absorbing; only rst exits.
- Watchdog:
  - Counter of width clog2(TIMEOUT+1), cleared on entry to WAIT_EX/WAIT_WB, incremented each wait cycle.
  - If count == TIMEOUT-1 and there is no qualifying event → ERR and err_timeout=1.
  - A qualifying event in the same cycle as expiry wins over the timeout.
- Outputs:
  - stall_if = (state≠IDLE) | (state==IDLE & any id_*).
  - flush_id_ex = state ∈ {WAIT_EX, WAIT_WB, REDIRECT, ERR}. It is never asserted in the decode cycle, so the control op itself advances into EX.
  - pc_load = flush_if_id = (state==REDIRECT).
  - pc_next holds its last value outside REDIRECT.
- stall_if is forced to 0 while rst is high.

## Timing
- Reset values: state IDLE, counter 0, pc_next 0. stall_if, flush_id_ex, flush_if_id, pc_load, busy and err_timeout are all 0.
- Decode cycle T: stall_if=1 (combinational); busy=0.
- T+1: WAIT_*, busy=1, flush_id_ex=1, stall_if=1.
- Taken resolve or return valid at cycle R:
  - R+1 REDIRECT: pc_load=1, flush_if_id=1, stall_if=1.
  - R+2 IDLE: fetch resumes at pc_next.
- Not-taken resolve at R: R+1 IDLE, stall released. The held IF/ID instruction proceeds and may itself be a control op accepted at R+1.
- Minimum redirect penalty: resolve in T+1 gives 3 stall cycles.
- Reset asserted mid-wait or in REDIRECT:
  - Returns to IDLE next edge.
  - A pending pc_load is dropped.
  - err_timeout clears.

## Test plan
- Taken branch: id_branch at T; ex_resolve=1, ex_pc_src=1, ex_pc_target=0x0123 at T+1 → pc_load=1, flush_if_id=1, pc_next=0x0123 at T+2; stall_if=0 at T+3.
- Not-taken branch: id_branch at T; ex_resolve=1, ex_pc_src=0 at T+3 → never pc_load; stall_if=0 and busy=0 at T+4; flush_id_ex=1 during T+1..T+3.
- Return: id_ret at T; ex_resolve pulse at T+2 (ignored); wb_ret_valid=1, wb_ret_addr=0xBEEF at T+4 → pc_load=1, pc_next=0xBEEF at T+5.
- Priority and ignore: id_branch=id_ret=1 at T → WAIT_EX entered; id_call pulsed during WAIT_EX → no effect after resolve.
- Watchdog: id_call with no resolve for TIMEOUT=15 cycles → err_timeout=1, stall_if=1 held. Resolve coincident with the 15th wait cycle → REDIRECT instead. rst → all outputs 0.
- Back-to-back: not-taken resolve, then id_branch in the following IDLE cycle → new WAIT_EX; watchdog counter restarts at 0.
